// File: rtl/fma_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fma_operand_loader
//  Purpose  : Operand entry front end for the bf16 fused multiply-add path.
//             Assembles three bf16 operands (a, b, c) one byte at a time from
//             an 8-bit switch bank and a load push-button. Both buttons are
//             synchronized, debounced and edge-detected. A complete set is
//             handed to the datapath with a one-cycle start strobe; an echo
//             word mirrors entry progress for the display driver.
//
//  Ports    : clk            system clock, rising edge
//             reset          asynchronous active-low reset
//             sw[7:0]        raw switch byte, sampled on a load event
//             btn_load       raw load button (active high)
//             btn_clear      raw clear button (active high)
//             a/b/c[15:0]    registered operands, held until next full set
//             start          one-cycle pulse when a/b/c update
//             operands_valid a complete set was delivered since reset/clear
//             byte_idx[2:0]  entry position 0..5, 6 = DONE
//             echo[15:0]     registered display word
//             nan_flag       sticky: a NaN was canonicalized on delivery
//
//  Options  : BF16_CANON_NAN_EN - when defined, NaN operands are replaced by
//             16'h7FC0 at delivery and nan_flag is raised. When undefined,
//             operands pass bit-exact and nan_flag stays 0.
//
//  Revision : 1.0  initial release
// ============================================================================
module fma_operand_loader #(
  parameter int DEB_CNT = 500000,
  parameter int CNT_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sw,
  input  logic        btn_load,
  input  logic        btn_clear,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic        start,
  output logic        operands_valid,
  output logic [2:0]  byte_idx,
  output logic [15:0] echo,
  output logic        nan_flag
);

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CNT - 1);

  typedef enum logic [2:0] {
    S_A_HI = 3'd0,
    S_A_LO = 3'd1,
    S_B_HI = 3'd2,
    S_B_LO = 3'd3,
    S_C_HI = 3'd4,
    S_C_LO = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Button conditioning: bit 0 = load, bit 1 = clear
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_rise;

  assign w_btn_raw = {btn_clear, btn_load};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]       r_sync;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synchronized input disagrees with the
    // accepted state; any agreement (bounce back) restarts the stability run.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync  <= 2'b00;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync  <= {r_sync[0], w_btn_raw[gi]};
        r_deb_d <= r_deb;
        if (r_sync[1] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_last) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_rise[gi] = r_deb & ~r_deb_d;
  end

  logic w_load_ev;
  logic w_clear_ev;

  assign w_load_ev  = w_rise[0];
  assign w_clear_ev = w_rise[1];

  // --------------------------------------------------------------------------
  // Staging and delivery
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [47:0] r_stage;    // {a_hi, a_lo, b_hi, b_lo, c_hi, c_lo}
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic        r_start;
  logic        r_valid;
  logic [15:0] r_echo;
  logic        r_nan;

  // The final byte is taken straight from sw so the set is delivered on the
  // same edge that captures it.
  logic [47:0] w_set;
  logic [15:0] w_a_raw;
  logic [15:0] w_b_raw;
  logic [15:0] w_c_raw;
  logic [15:0] w_a_out;
  logic [15:0] w_b_out;
  logic [15:0] w_c_out;
  logic        w_nan_any;

  assign w_set   = {r_stage[47:8], sw};
  assign w_a_raw = w_set[47:32];
  assign w_b_raw = w_set[31:16];
  assign w_c_raw = w_set[15:0];

`ifdef BF16_CANON_NAN_EN
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
  endfunction

  assign w_a_out   = is_nan(w_a_raw) ? 16'h7FC0 : w_a_raw;
  assign w_b_out   = is_nan(w_b_raw) ? 16'h7FC0 : w_b_raw;
  assign w_c_out   = is_nan(w_c_raw) ? 16'h7FC0 : w_c_raw;
  assign w_nan_any = is_nan(w_a_raw) | is_nan(w_b_raw) | is_nan(w_c_raw);
`else
  assign w_a_out   = w_a_raw;
  assign w_b_out   = w_b_raw;
  assign w_c_out   = w_c_raw;
  assign w_nan_any = 1'b0;
`endif

  // Echo is computed from the current state and registered below, so the
  // display sees sw/state one cycle late.
  logic [15:0] w_echo;

  always_comb begin
    w_echo = 16'h0000;
    case (r_state)
      S_A_HI, S_B_HI, S_C_HI: w_echo = {sw, 8'h00};
      S_A_LO:                 w_echo = {r_stage[47:40], sw};
      S_B_LO:                 w_echo = {r_stage[31:24], sw};
      S_C_LO:                 w_echo = {r_stage[15:8], sw};
      S_DONE:                 w_echo = r_c;
      default:                w_echo = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_A_HI;
      r_stage <= 48'h0;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_c     <= 16'h0000;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_echo  <= 16'h0000;
      r_nan   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_echo  <= w_echo;
      // Clear has priority; a coincident load is dropped. Operands are held.
      if (w_clear_ev) begin
        r_stage <= 48'h0;
        r_state <= S_A_HI;
        r_valid <= 1'b0;
        r_nan   <= 1'b0;
      end else if (w_load_ev) begin
        case (r_state)
          S_A_HI: begin r_stage[47:40] <= sw; r_state <= S_A_LO; end
          S_A_LO: begin r_stage[39:32] <= sw; r_state <= S_B_HI; end
          S_B_HI: begin r_stage[31:24] <= sw; r_state <= S_B_LO; end
          S_B_LO: begin r_stage[23:16] <= sw; r_state <= S_C_HI; end
          S_C_HI: begin r_stage[15:8]  <= sw; r_state <= S_C_LO; end
          S_C_LO: begin
            r_stage[7:0] <= sw;
            r_a          <= w_a_out;
            r_b          <= w_b_out;
            r_c          <= w_c_out;
            r_start      <= 1'b1;
            r_valid      <= 1'b1;
            r_nan        <= r_nan | w_nan_any;
            r_state      <= S_DONE;
          end
          // A new entry begins directly with A high; old operands stay valid.
          S_DONE: begin r_stage[47:40] <= sw; r_state <= S_A_LO; end
          default: r_state <= S_A_HI;
        endcase
      end
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign c              = r_c;
  assign start          = r_start;
  assign operands_valid = r_valid;
  assign byte_idx       = r_state;
  assign echo           = r_echo;
  assign nan_flag       = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fma_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fma_operand_loader
//  Purpose  : Self-checking bench for fma_operand_loader (DEB_CNT = 4).
//             Button presses are modelled at the press level: a clean press
//             yields one event, a short glitch yields none. Delivered operand
//             sets are queued and checked whenever start is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fma_operand_loader;

  localparam int DEB  = 4;
  localparam int CW   = 3;
  localparam int HOLD = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic        btn_load = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] a, b, c, echo;
  logic        start, operands_valid, nan_flag;
  logic [2:0]  byte_idx;

  fma_operand_loader #(.DEB_CNT(DEB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load),
    .btn_clear(btn_clear), .a(a), .b(b), .c(c), .start(start),
    .operands_valid(operands_valid), .byte_idx(byte_idx), .echo(echo),
    .nan_flag(nan_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ec;
    logic        enan;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_state = 0;
  logic [7:0]  m_bytes [6];
  logic [15:0] m_a = 0, m_b = 0, m_c = 0;
  logic        m_valid = 0, m_nan = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] canon(input logic [15:0] v);
`ifdef BF16_CANON_NAN_EN
    if (v[14:7] == 8'hFF && v[6:0] != 7'd0) return 16'h7FC0;
`endif
    return v;
  endfunction

  function automatic logic [15:0] exp_echo(input logic [7:0] s);
    case (m_state)
      0, 2, 4: return {s, 8'h00};
      1:       return {m_bytes[0], s};
      3:       return {m_bytes[2], s};
      5:       return {m_bytes[4], s};
      default: return m_c;
    endcase
  endfunction

  task automatic model_load(input logic [7:0] v);
    logic [15:0] ra, rb, rc;
    exp_t e;
    if (m_state == 6) begin
      m_bytes[0] = v;
      m_state = 1;
    end else begin
      m_bytes[m_state] = v;
      if (m_state == 5) begin
        ra = {m_bytes[0], m_bytes[1]};
        rb = {m_bytes[2], m_bytes[3]};
        rc = {m_bytes[4], m_bytes[5]};
        m_a = canon(ra);
        m_b = canon(rb);
        m_c = canon(rc);
        if (m_a != ra || m_b != rb || m_c != rc) m_nan = 1'b1;
        m_valid = 1'b1;
        e = '{ea: m_a, eb: m_b, ec: m_c, enan: m_nan};
        q.push_back(e);
        m_state = 6;
      end else begin
        m_state++;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_bytes[i] = 8'h00;
    m_state = 0;
    m_valid = 1'b0;
    m_nan   = 1'b0;
  endtask

  // Drive a clean press of the selected buttons, then a long quiet gap.
  task automatic drive(input logic ld, input logic cl, input int hold);
    @(posedge clk); #1;
    btn_load  = ld;
    btn_clear = cl;
    repeat (hold) @(posedge clk);
    #1;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] v, input int hold);
    model_load(v);
    sw = v;
    drive(1'b1, 1'b0, hold);
  endtask

  task automatic do_clear();
    model_clear();
    drive(1'b0, 1'b1, HOLD);
  endtask

  // Runs of load shorter than DEB_CNT with short gaps: never accepted.
  task automatic glitch();
    @(posedge clk); #1;
    repeat (4) begin
      btn_load = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      btn_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    chk("byte_idx", {45'd0, byte_idx}, 48'(m_state));
    chk("operands_valid", {47'd0, operands_valid}, {47'd0, m_valid});
    chk("nan_flag", {47'd0, nan_flag}, {47'd0, m_nan});
    chk("a", {32'd0, a}, {32'd0, m_a});
    chk("b", {32'd0, b}, {32'd0, m_b});
    chk("c", {32'd0, c}, {32'd0, m_c});
    sw = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("echo", {32'd0, echo}, {32'd0, exp_echo(sw)});
  endtask

  // Monitor: every start pulse pops one expected operand set.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_start = 1'b0;
    end else begin
      if (start) begin
        chk("start_width", {47'd0, prev_start}, 48'd0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL start_unexpected: got start=1 expected no delivery");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_a", {32'd0, a}, {32'd0, e.ea});
          chk("sb_b", {32'd0, b}, {32'd0, e.eb});
          chk("sb_c", {32'd0, c}, {32'd0, e.ec});
          chk("sb_nan", {47'd0, nan_flag}, {47'd0, e.enan});
          chk("sb_valid", {47'd0, operands_valid}, 48'd1);
        end
      end
      prev_start = start;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_a", {32'd0, a}, 48'd0);
    chk("rst_b", {32'd0, b}, 48'd0);
    chk("rst_c", {32'd0, c}, 48'd0);
    chk("rst_start", {47'd0, start}, 48'd0);
    chk("rst_valid", {47'd0, operands_valid}, 48'd0);
    chk("rst_idx", {45'd0, byte_idx}, 48'd0);
    chk("rst_echo", {32'd0, echo}, 48'd0);
    chk("rst_nan", {47'd0, nan_flag}, 48'd0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] nanpick [4];
    nanpick[0] = 8'h7F; nanpick[1] = 8'hFF; nanpick[2] = 8'h81; nanpick[3] = 8'h80;
    for (int i = 0; i < 6; i++) m_bytes[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed set from the reference example
    press(8'h4B, HOLD); check_state();
    press(8'hB4, HOLD); check_state();
    press(8'h8B, HOLD); check_state();
    press(8'h6E, HOLD); check_state();
    press(8'hD7, HOLD); check_state();
    press(8'hB7, HOLD); check_state();
    chk("set1_a", {32'd0, a}, {32'd0, 16'h4BB4});
    chk("set1_b", {32'd0, b}, {32'd0, 16'h8B6E});
    chk("set1_c", {32'd0, c}, {32'd0, 16'hD7B7});
    chk("set1_echo", {32'd0, echo}, {32'd0, 16'hD7B7});

    // Glitches give nothing; a 100-cycle hold gives one capture (DONE -> A_LO)
    glitch(); check_state();
    press(8'h12, 100); check_state();

    // Three bytes in, then clear: operands held
    press(8'h34, HOLD); check_state();
    press(8'h56, HOLD); check_state();
    do_clear(); check_state();
    chk("clr_a", {32'd0, a}, {32'd0, 16'h4BB4});
    chk("clr_valid", {47'd0, operands_valid}, 48'd0);
    for (int i = 0; i < 6; i++) begin
      press(8'($urandom), HOLD);
      check_state();
    end

    // Coincident load and clear at byte_idx 3: clear wins
    do_clear();
    press(8'hA1, HOLD); press(8'hA2, HOLD); press(8'hA3, HOLD);
    check_state();
    sw = 8'h5A;
    model_clear();
    drive(1'b1, 1'b1, HOLD);
    check_state();
    chk("both_idx", {45'd0, byte_idx}, 48'd0);

    // NaN operand in c
    do_clear();
    press(8'h3F, HOLD); press(8'h80, HOLD); press(8'h40, HOLD);
    press(8'h00, HOLD); press(8'h7F, HOLD); press(8'h81, HOLD);
    check_state();
`ifdef BF16_CANON_NAN_EN
    chk("nan_c", {32'd0, c}, {32'd0, 16'h7FC0});
    chk("nan_flag_set", {47'd0, nan_flag}, 48'd1);
`else
    chk("nan_c", {32'd0, c}, {32'd0, 16'h7F81});
    chk("nan_flag_set", {47'd0, nan_flag}, 48'd0);
`endif
    do_clear(); check_state();

    // Randomized mix of loads, clears and glitches
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_clear();
      end else if (r == 1) begin
        glitch();
      end else begin
        if ($urandom_range(0, 1) == 0) v = nanpick[$urandom_range(0, 3)];
        else v = 8'($urandom);
        press(v, HOLD);
      end
      check_state();
    end

    // Asynchronous reset at byte_idx 4
    do_clear();
    for (int i = 0; i < 4; i++) press(8'($urandom), HOLD);
    check_state();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    press(8'hC3, HOLD); check_state();
    chk("post_rst_idx", {45'd0, byte_idx}, 48'd1);

    chk("queue_empty", 48'(q.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
